// File: rtl/pic12f508_pkg.sv
// Shared constants for the PIC12F508 Timer0 slice: OPTION bit layout,
// file address, prescaler sizing and post-write inhibit length.
package pic12f508_pkg;
  localparam int OPT_PS_LSB  = 0;
  localparam int OPT_PS_MSB  = 2;
  localparam int OPT_PSA     = 3;
  localparam int OPT_T0SE    = 4;
  localparam int OPT_T0CS    = 5;
  localparam logic [4:0] TMR0_ADDR = 5'h01;
  localparam int PRE_W_DEF   = 8;
  localparam int INHIBIT_LEN = 2;
  localparam int BLANK_CLKS  = 3;

  typedef enum logic {SRC_CYC = 1'b0, SRC_T0CKI = 1'b1} t0_src_e;

  // Low (ps+1) bits set: prescaler taps for ratio 2^(ps+1).
  function automatic logic [7:0] ps_mask(input logic [2:0] ps);
    return 8'((9'd2 << ps) - 9'd1);
  endfunction
endpackage

// File: rtl/pic12f508_tmr0_if.sv
// Control/data bundle between the core and the Timer0 block.
interface pic12f508_tmr0_if;
  logic       cyc_en;
  logic       t0cs;
  logic       t0se;
  logic       psa;
  logic [2:0] ps;
  logic       t0cki;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clrwdt;
  logic       wdt_base;
  logic [7:0] tmr0;
  logic       ovf;
  logic       wdt_tick;

  modport master (output cyc_en, t0cs, t0se, psa, ps, t0cki, wr_en, wr_data,
                         clrwdt, wdt_base,
                  input  tmr0, ovf, wdt_tick);
  modport slave  (input  cyc_en, t0cs, t0se, psa, ps, t0cki, wr_en, wr_data,
                         clrwdt, wdt_base,
                  output tmr0, ovf, wdt_tick);
endinterface

// File: rtl/pic12f508_tmr0_t0cki_sync.sv
// T0CKI pin synchronizer with post-reset blanking and polarity-selected
// single-clk edge pulse.
module pic12f508_tmr0_t0cki_sync
  import pic12f508_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  input  logic fall,
  output logic edge_pulse
);
  logic       s1, s2, hist;
  logic [1:0] blank_cnt;
  logic       armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      hist      <= 1'b0;
      blank_cnt <= '0;
    end else begin
      s1   <= pin;
      s2   <= s1;
      hist <= s2;
      if (!armed) blank_cnt <= blank_cnt + 2'd1;
    end
  end

  // History keeps tracking during blanking, so a pin already high at
  // reset release settles without producing an edge.
  assign armed      = (blank_cnt == 2'(BLANK_CLKS));
  assign edge_pulse = armed & (fall ? (hist & ~s2) : (s2 & ~hist));
endmodule

// File: rtl/pic12f508_tmr0.sv
// Timer0: 8-bit TMR0 with the prescaler shared between TMR0 and the WDT,
// clocked by the instruction cycle or by T0CKI edges.
module pic12f508_tmr0
  import pic12f508_pkg::*;
#(
  parameter int PRE_W = PRE_W_DEF
) (
  input logic              clk,
  input logic              rst_n,
  pic12f508_tmr0_if.slave  bus
);
  logic             edge_pulse, pending;
  logic             cnt_evt, pre_evt, pre_clr, hit, inc;
  logic [PRE_W-1:0] pre, mask;
  logic [1:0]       inh;
  logic [7:0]       tmr0_q;
  logic             ovf_q, tick_q;

  pic12f508_tmr0_t0cki_sync u_t0cki_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .pin        (bus.t0cki),
    .fall       (bus.t0se),
    .edge_pulse (edge_pulse)
  );

  always_comb begin
    mask    = PRE_W'(ps_mask(bus.ps));
    hit     = ((pre & mask) == mask);
    cnt_evt = bus.cyc_en & (~bus.t0cs | pending);
    pre_evt = bus.psa ? bus.wdt_base : cnt_evt;
    pre_clr = bus.psa ? bus.clrwdt : bus.wr_en;
    inc     = cnt_evt & (bus.psa | hit) & (inh == 2'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      pre     <= '0;
      inh     <= '0;
      tmr0_q  <= '0;
      ovf_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      // Any number of edges within one instruction cycle collapse to one.
      if (bus.t0cs && edge_pulse)        pending <= 1'b1;
      else if (bus.cyc_en || !bus.t0cs)  pending <= 1'b0;

      if (pre_clr)      pre <= '0;
      else if (pre_evt) pre <= pre + 1'b1;

      if (bus.wr_en)                     inh <= 2'(INHIBIT_LEN);
      else if (bus.cyc_en && inh != '0)  inh <= inh - 2'd1;

      ovf_q <= 1'b0;
      if (bus.wr_en) begin
        tmr0_q <= bus.wr_data;
      end else if (inc) begin
        tmr0_q <= tmr0_q + 8'd1;
        ovf_q  <= (tmr0_q == 8'hFF);
      end

      tick_q <= bus.psa ? (bus.wdt_base & hit) : bus.wdt_base;
    end
  end

  assign bus.tmr0     = tmr0_q;
  assign bus.ovf      = ovf_q;
  assign bus.wdt_tick = tick_q;
endmodule

// File: tb/tb_pic12f508_tmr0.sv
// Self-checking bench for pic12f508_tmr0: table vectors, directed corner
// sequences and a randomized run against an arithmetic reference model.
module tb_pic12f508_tmr0;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pic12f508_tmr0_if io();
  pic12f508_tmr0 #(.PRE_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(io.slave));

  int errs = 0, checks = 0;
  int phase = 0;
  bit auto_cyc = 1'b1;

  typedef struct {
    bit         psa;
    logic [2:0] ps;
    int         n;
    logic [7:0] exp_tmr0;
  } vec_t;
  vec_t vt[6];

  int m_tmr, m_pre, m_inh;
  bit m_ovf, m_tick;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      if (errs <= 20) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance one clk; outputs are settled on return, inputs may be driven.
  task automatic clk1();
    @(posedge clk); #1;
    phase = (phase + 1) % 4;
    io.cyc_en = auto_cyc && (phase == 0);
  endtask

  task automatic cycs(input int n);
    for (int i = 0; i < n; i++) begin
      int g;
      g = 0;
      while (!io.cyc_en && g < 8) begin clk1(); g++; end
      clk1();
    end
  endtask

  task automatic idle_inputs(input logic pin);
    io.cyc_en = 0; io.t0cs = 0; io.t0se = 0; io.psa = 1; io.ps = 0;
    io.t0cki = pin; io.wr_en = 0; io.wr_data = 0; io.clrwdt = 0; io.wdt_base = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs(1'b0);
    auto_cyc = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    phase = 0;
  endtask

  task automatic pulses(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      io.t0cki = 1'b1; repeat (hi) clk1();
      io.t0cki = 1'b0; repeat (lo) clk1();
    end
  endtask

  task automatic wdt_pulse(output int t_now, output int t_late);
    io.wdt_base = 1'b1; clk1(); io.wdt_base = 1'b0;
    t_now = int'(io.wdt_tick);
    clk1();
    t_late = int'(io.wdt_tick);
  endtask

  // Reference: prescaler[ps:0] all ones <=> (pre+1) is a multiple of 2^(ps+1).
  task automatic model_step();
    int  ratio;
    bit  evt, pe, hit;
    ratio = 2 << io.ps;
    evt   = io.cyc_en;
    pe    = io.psa ? io.wdt_base : evt;
    hit   = ((m_pre + 1) % ratio) == 0;
    m_tick = io.psa ? (io.wdt_base && hit) : io.wdt_base;
    m_ovf  = 1'b0;
    if (io.wr_en) m_tmr = io.wr_data;
    else if (evt && (io.psa || hit) && m_inh == 0) begin
      m_ovf = (m_tmr == 255);
      m_tmr = (m_tmr + 1) % 256;
    end
    if (io.wr_en) m_inh = 2;
    else if (evt && m_inh > 0) m_inh--;
    if (io.psa ? io.clrwdt : io.wr_en) m_pre = 0;
    else if (pe) m_pre = (m_pre + 1) % 256;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errs);
    $fatal(1);
  end

  initial begin
    int base, novf, tn, tl, tsum;
    vt[0] = '{1'b1, 3'd0,   5, 8'd5};
    vt[1] = '{1'b0, 3'd2,   8, 8'd1};
    vt[2] = '{1'b0, 3'd2,  32, 8'd4};
    vt[3] = '{1'b0, 3'd0,   7, 8'd3};
    vt[4] = '{1'b0, 3'd7, 256, 8'd1};
    vt[5] = '{1'b1, 3'd5, 300, 8'd44};

    do_reset();
    chk("reset_tmr0", io.tmr0, 0);
    chk("reset_ovf", io.ovf, 0);
    chk("reset_tick", io.wdt_tick, 0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      io.psa = vt[i].psa; io.ps = vt[i].ps;
      cycs(vt[i].n);
      chk($sformatf("vec%0d_tmr0", i), io.tmr0, vt[i].exp_tmr0);
    end

    // 256 instruction cycles: full wrap, single ovf on the last one
    do_reset();
    novf = 0;
    for (int i = 0; i < 256; i++) begin
      cycs(1);
      if (io.ovf) novf++;
      if (i == 254) chk("pre_wrap_ff", io.tmr0, 8'hFF);
      if (i == 255) chk("ovf_at_256", io.ovf, 1);
    end
    chk("wrap_tmr0", io.tmr0, 0);
    chk("ovf_count", novf, 1);

    // T0CKI falling then rising edges, 4/4 clk pulses
    for (int pol = 1; pol >= 0; pol--) begin
      do_reset();
      io.t0cs = 1; io.t0se = 1'(pol); io.psa = 1;
      repeat (5) clk1();
      pulses(10, 4, 4);
      repeat (16) clk1();
      chk($sformatf("t0cki_se%0d", pol), io.tmr0, 10);
    end
    base = int'(io.tmr0);
    io.t0cki = 1'b1; clk1(); io.t0cki = 1'b0;
    repeat (16) clk1();
    chk("glitch_at_most_once", (int'(io.tmr0) - base) <= 1, 1);

    // Several edges with no cyc_en: one pending count only
    do_reset();
    io.t0cs = 1; io.t0se = 0; io.psa = 1; auto_cyc = 0;
    repeat (5) clk1();
    pulses(3, 2, 2);
    repeat (6) clk1();
    chk("pending_no_cyc", io.tmr0, 0);
    io.cyc_en = 1; clk1();
    chk("pending_once", io.tmr0, 1);
    repeat (4) clk1();
    io.cyc_en = 1; clk1();
    chk("pending_cleared", io.tmr0, 1);

    // Write mid-prescale: clear, 2-strobe inhibit, then wrap on schedule
    do_reset();
    io.psa = 0; io.ps = 0;
    cycs(3);
    chk("pre_write", io.tmr0, 1);
    io.wr_en = 1; io.wr_data = 8'hFE; clk1(); io.wr_en = 0;
    chk("write_val", io.tmr0, 8'hFE);
    cycs(2); chk("inhibit", io.tmr0, 8'hFE);
    cycs(1); chk("after_inh_no_hit", io.tmr0, 8'hFE);
    cycs(1); chk("after_inh_ff", io.tmr0, 8'hFF);
    cycs(1); chk("hold_ff", io.tmr0, 8'hFF);
    cycs(1); chk("wrap_00", io.tmr0, 0);
    chk("wrap_ovf", io.ovf, 1);
    clk1(); chk("ovf_one_clk", io.ovf, 0);

    // Write coinciding with a wrapping increment
    io.psa = 1;
    io.wr_en = 1; io.wr_data = 8'hFF; clk1(); io.wr_en = 0;
    cycs(2);
    chk("ff_inhibited", io.tmr0, 8'hFF);
    for (int g = 0; g < 8 && !io.cyc_en; g++) clk1();
    io.wr_en = 1; io.wr_data = 8'h10; clk1(); io.wr_en = 0;
    chk("write_wins", io.tmr0, 8'h10);
    chk("write_no_ovf", io.ovf, 0);

    // WDT path
    do_reset();
    auto_cyc = 0; io.psa = 1; io.ps = 0;
    tsum = 0;
    for (int i = 0; i < 4; i++) begin wdt_pulse(tn, tl); tsum += tn + tl; end
    chk("wdt_4_pulses", tsum, 2);
    wdt_pulse(tn, tl);
    io.clrwdt = 1; clk1(); io.clrwdt = 0;
    wdt_pulse(tn, tl);
    chk("wdt_clr_first", tn + tl, 0);
    wdt_pulse(tn, tl);
    chk("wdt_clr_second", tn + tl, 1);
    io.psa = 0;
    for (int i = 0; i < 3; i++) begin
      wdt_pulse(tn, tl);
      chk("wdt_mirror_now", tn, 1);
      chk("wdt_mirror_late", tl, 0);
    end

    // Asynchronous reset mid-count, pin held high through release
    do_reset();
    io.wr_en = 1; io.wr_data = 8'h55; clk1(); io.wr_en = 0;
    chk("pre_reset_55", io.tmr0, 8'h55);
    io.t0cs = 1; io.t0se = 0; io.t0cki = 1;
    rst_n = 1'b0;
    #2;
    chk("async_rst_tmr0", io.tmr0, 0);
    chk("async_rst_ovf", io.ovf, 0);
    chk("async_rst_tick", io.wdt_tick, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) clk1();
    chk("no_spurious_edge", io.tmr0, 0);

    // Randomized run against the reference model (internal clock source)
    do_reset();
    io.psa = 0; io.ps = 1;
    m_tmr = 0; m_pre = 0; m_inh = 0;
    for (int it = 0; it < 2500; it++) begin
      if ($urandom_range(0, 99) == 0) begin
        io.psa = 1'($urandom_range(0, 1));
        io.ps  = 3'($urandom_range(0, 7));
      end
      io.wr_en    = ($urandom_range(0, 29) == 0);
      io.wr_data  = 8'($urandom);
      io.wdt_base = ($urandom_range(0, 3) == 0);
      io.clrwdt   = !io.wdt_base && ($urandom_range(0, 19) == 0);
      model_step();
      clk1();
      chk("rand_tmr0", io.tmr0, m_tmr);
      chk("rand_ovf", io.ovf, m_ovf);
      chk("rand_tick", io.wdt_tick, m_tick);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/pic12f508_tmr0.md
# pic12f508_tmr0

Timer0 stage of the PIC12F508 core: 8-bit TMR0 counter with the shared 8-bit prescaler, clocked either by the instruction cycle or by edges on the T0CKI pin (GP2). It sits directly downstream of the GPIO input stage, consuming the raw GP2 level it presents, and upstream of the register file (TMR0 read data) and the watchdog (prescaled WDT tick).

## Interface
Parameters:
- PRE_W, 8, prescaler counter width (ratios 1:2 … 1:256)

Ports:
- clk  in  1  core clock (Fosc)
- rst_n  in  1  asynchronous, active-low reset
- cyc_en  in  1  one-clk strobe per instruction cycle (Fosc/4)
- t0cs  in  1  OPTION.T0CS: 0 = instruction cycle, 1 = T0CKI edges
- t0se  in  1  OPTION.T0SE: 0 = rising edge, 1 = falling edge
- psa  in  1  OPTION.PSA: 0 = prescaler to TMR0, 1 = prescaler to WDT
- ps  in  3  OPTION.PS<2:0>, ratio 2^(ps+1)
- t0cki  in  1  raw GP2 pin level from the GPIO stage, asynchronous
- wr_en  in  1  one-clk strobe, software write to TMR0
- wr_data  in  8  value written
- clrwdt  in  1  one-clk strobe, CLRWDT/SLEEP executed
- wdt_base  in  1  one-clk strobe from the WDT oscillator divider
- tmr0  out  8  current TMR0 value
- ovf  out  1  one-clk pulse on 0xFF→0x00 wrap
- wdt_tick  out  1  one-clk pulse to the watchdog counter

## Operation
- Count event source: t0cs=0 → every cyc_en; t0cs=1 → synchronized T0CKI edge of selected polarity, held in a pending flag and consumed at the next cyc_en (multiple edges within one instruction cycle count once).
- psa=0: each count event increments the prescaler; TMR0 increments on that event iff prescaler[ps:0] is all ones before the increment. psa=1: each count event increments TMR0 directly.
- WDT path: psa=1 → wdt_base events drive the prescaler, wdt_tick fires on the same all-ones rule; psa=0 → wdt_tick = wdt_base.
- Changing ps or psa does not clear the prescaler; the new ratio applies from the next event.
- Prescaler cleared (to 0) by: wr_en while psa=0; clrwdt while psa=1; reset.
- Write: tmr0 ← wr_data; increments inhibited for the next 2 cyc_en strobes after the write (prescaler still counts when psa=0 except the clear on the write itself).
- Simultaneous wr_en and increment: write wins, no ovf.
- Wrap: 0xFF + 1 = 0x00, ovf pulses for one clk; no sticky flag (the part has no TMR0 interrupt).

## Timing
- Reset values: tmr0=0x00, prescaler=0, ovf=0, wdt_tick=0, inhibit count=0, pending=0, sync flops=0.
- Internal source: tmr0 updates on the clk edge that samples cyc_en; visible the following cycle.
- T0CKI: 2-flop synchronizer plus one edge-history flop; edge detection disabled for the first 3 clks after reset deassert. Pin change → pending set 3 clks later → counted at the next cyc_en. High and low phases ≥2 clk each are guaranteed; shorter pulses may be lost.
- wdt_tick: registered, asserted the clk after the qualifying wdt_base.
- Reset asserted mid-count: all state clears immediately (asynchronous); no partial increment survives.

## Structure
- pic12f508_pkg: OPTION bit positions (PS 2:0, PSA 3, T0SE 4, T0CS 5), TMR0 file address 0x01, PRE_W default, inhibit length constant 2.
- Sub-module t0cki_sync: synchronizer, reset-blanking counter and polarity-selected edge detector; output a one-clk edge pulse.
- Top contains prescaler, pending flag, inhibit counter, TMR0 and WDT mux.

## Test plan
- t0cs=0, psa=1, 256 cyc_en from reset → tmr0 returns to 0x00, exactly one ovf pulse at the 256th.
- t0cs=0, psa=0, ps=3'b010 (1:8) → tmr0=0x01 after 8 cyc_en, 0x04 after 32.
- t0cs=1, t0se=1, 10 clean pulses (4 clk high/4 low) on t0cki, psa=1 → tmr0=0x0A; t0se=0 repeat → rising edges counted equally; 1-clk glitch never counts twice.
- wr_en with 0xFE, psa=0 mid-prescale → prescaler 0, next 2 cyc_en no increment, then 0xFF, wrap with ovf on schedule.
- psa=1, ps=3'b000, 4 wdt_base pulses → 2 wdt_tick pulses; clrwdt after 1 pulse → next tick needs 2 fresh pulses; psa=0 → wdt_tick mirrors wdt_base.
- rst_n asserted between cyc_en strobes with tmr0=0x55 → tmr0, wdt_tick, ovf 0 immediately; t0cki held high through reset release → no spurious count.
